// File: rtl/snpu_entropy_harvester.sv
// snpu_entropy_harvester
// Harvests entropy from the SNPU free-running random-generator bank. Each
// generator is frozen in turn, its word is sampled through a 2-FF
// synchronizer, von Neumann debiased into an LSB-first byte accumulator and
// screened by a stuck-word health test. Debiased bytes leave on a
// valid/ready stream.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   harvesting enable (checked only between words)
//   rnd_in      in   16-bit bank word, asynchronous to clk
//   rnd_freeze  out  freeze request to the bank (registered)
//   rnd_addr    out  generator select to the bank (registered)
//   byte_data   out  debiased byte
//   byte_valid  out  byte_data holds a valid byte
//   byte_ready  in   sink accepts byte_data when byte_valid is high
//   fault       out  sticky health-test failure
module snpu_entropy_harvester #(
  parameter int unsigned RND_N       = 36,
  parameter int unsigned ADDR_W      = $clog2(RND_N),
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned STUCK_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [15:0]       rnd_in,
  output logic              rnd_freeze,
  output logic [ADDR_W-1:0] rnd_addr,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              fault
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PAIR_W  = 3;
  localparam int unsigned ACC_CW  = 4;
  localparam int unsigned FRZ_CYC = SETTLE + 2;
  localparam int unsigned FRZ_W   = $clog2(FRZ_CYC + 1);
  localparam int unsigned STK_W   = $clog2(STUCK_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FREEZE  = 3'd1,
    SAMPLE  = 3'd2,
    EXTRACT = 3'd3,
    ADVANCE = 3'd4
  } state_e;

  state_e              state_q, state_d;

  logic [WORD_W-1:0]   sync1_q, sync2_q;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [FRZ_W-1:0]    frz_cnt_q, frz_cnt_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic [BYTE_W-1:0]   acc_q, acc_d;
  logic [ACC_CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [STK_W-1:0]    stuck_q, stuck_d;
  logic                fault_q, fault_d;
  logic                freeze_q, freeze_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;

  logic                acc_full_c;
  logic                slot_load_c;
  logic                word_stuck_c;
  logic                stuck_trip_c;
  logic                pair_go_c;
  logic                bit_a_c;
  logic                bit_b_c;

  // Shared decode used by both FSM combinational processes.
  always_comb begin
    acc_full_c   = (acc_cnt_q == ACC_CW'(BYTE_W));
    // Output slot is free when empty or being drained this cycle.
    slot_load_c  = acc_full_c && (!valid_q || byte_ready);
    word_stuck_c = (sync2_q == '0) || (sync2_q == '1);
    // The sample that would bring the stuck run up to the limit.
    stuck_trip_c = word_stuck_c && ((32'(stuck_q) + 32'd1) >= STUCK_LIMIT);
    // A full accumulator stalls pair processing until the slot takes it.
    pair_go_c    = (state_q == EXTRACT) && !acc_full_c;
    bit_a_c      = word_q[{pair_q, 1'b0}];
    bit_b_c      = word_q[{pair_q, 1'b1}];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en && !fault_q && !acc_full_c) begin
          state_d = FREEZE;
        end
      end
      FREEZE: begin
        if (frz_cnt_q == FRZ_W'(FRZ_CYC - 1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        state_d = stuck_trip_c ? IDLE : EXTRACT;
      end
      EXTRACT: begin
        if (pair_go_c && (pair_q == PAIR_W'(7))) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM output and datapath next-state logic.
  always_comb begin
    word_d    = word_q;
    frz_cnt_d = '0;
    pair_d    = pair_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    stuck_d   = stuck_q;
    fault_d   = fault_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;

    // Freeze stays high from FREEZE entry through the SAMPLE cycle.
    freeze_d  = (state_d == FREEZE) || (state_d == SAMPLE);

    case (state_q)
      FREEZE: begin
        frz_cnt_d = frz_cnt_q + FRZ_W'(1);
      end
      SAMPLE: begin
        word_d  = sync2_q;
        pair_d  = '0;
        stuck_d = word_stuck_c ? (stuck_q + STK_W'(1)) : '0;
        if (stuck_trip_c) begin
          fault_d = 1'b1;
        end
      end
      EXTRACT: begin
        if (pair_go_c) begin
          pair_d = pair_q + PAIR_W'(1);
          // Von Neumann: unequal pair emits its first bit, shifted in
          // from the top so the first bit lands in bit 0.
          if (bit_a_c != bit_b_c) begin
            acc_d     = {bit_a_c, acc_q[BYTE_W-1:1]};
            acc_cnt_d = acc_cnt_q + ACC_CW'(1);
          end
        end
      end
      ADVANCE: begin
        addr_d = (addr_q == ADDR_W'(RND_N - 1)) ? '0 : (addr_q + ADDR_W'(1));
      end
      default: begin
      end
    endcase

    // Output slot; never coincides with a shift because a full
    // accumulator stalls extraction.
    if (slot_load_c) begin
      data_d    = acc_q;
      valid_d   = 1'b1;
      acc_cnt_d = '0;
    end else if (valid_q && byte_ready) begin
      valid_d   = 1'b0;
    end
  end

  // Datapath registers and bank-word synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      word_q    <= '0;
      frz_cnt_q <= '0;
      pair_q    <= '0;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      stuck_q   <= '0;
      fault_q   <= 1'b0;
      freeze_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= rnd_in;
      sync2_q   <= sync1_q;
      word_q    <= word_d;
      frz_cnt_q <= frz_cnt_d;
      pair_q    <= pair_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      stuck_q   <= stuck_d;
      fault_q   <= fault_d;
      freeze_q  <= freeze_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign rnd_freeze = freeze_q;
  assign rnd_addr   = addr_q;
  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_snpu_entropy_harvester.sv
// Bench for snpu_entropy_harvester: a bank model supplies a word on each
// freeze, a word-level model predicts bytes, addresses and fault.
`timescale 1ns/1ps
module tb_snpu_entropy_harvester;

  localparam int RND_N = 36;
  localparam int STUCK = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] rnd_in;
  logic        rnd_freeze;
  logic [5:0]  rnd_addr;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        fault;

  snpu_entropy_harvester dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rnd_in     (rnd_in),
    .rnd_freeze (rnd_freeze),
    .rnd_addr   (rnd_addr),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .fault      (fault)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  logic [7:0]  exp_bytes[$];
  logic [15:0] dir_q[$];
  logic [7:0]  m_acc;
  int          m_cnt;
  int          m_stuck;
  bit          m_fault;
  int          exp_addr;
  int          exp_total;
  bit          fixed_en;
  logic [15:0] fixed_word;

  // monitor state
  int          words_seen = 0;
  int          bytes_seen = 0;
  logic [7:0]  last_byte;
  logic [15:0] mon_w;
  bit          fz_prev, flt_prev, hold_v;
  logic [7:0]  hold_d;
  logic [7:0]  exp_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    exp_bytes.delete();
    dir_q.delete();
    m_acc     = 8'h00;
    m_cnt     = 0;
    m_stuck   = 0;
    m_fault   = 1'b0;
    exp_addr  = 0;
    exp_total = bytes_seen;
  endtask

  // Word-level reference: health test, von Neumann pairs, LSB-first bytes.
  task automatic model_word(input logic [15:0] w);
    if (w == 16'h0000 || w == 16'hFFFF) m_stuck++;
    else m_stuck = 0;
    if (m_stuck >= STUCK) begin
      m_fault = 1'b1;
      return;
    end
    for (int k = 0; k < 8; k++) begin
      if (w[2*k] != w[2*k+1]) begin
        m_acc[m_cnt] = w[2*k];
        m_cnt++;
        if (m_cnt == 8) begin
          exp_bytes.push_back(m_acc);
          exp_total++;
          m_cnt = 0;
        end
      end
    end
    exp_addr = (exp_addr + 1) % RND_N;
  endtask

  function automatic logic [15:0] pick_word();
    logic [15:0] w;
    int r;
    if (dir_q.size() > 0) return dir_q.pop_front();
    if (fixed_en) return fixed_word;
    r = $urandom_range(0, 15);
    if (r == 0 && m_stuck < STUCK - 1) return 16'hFFFF;
    if (r == 1 && m_stuck < STUCK - 1) return 16'h0000;
    w = 16'($urandom);
    if ((w == 16'h0000 || w == 16'hFFFF) && m_stuck >= STUCK - 1) w = 16'h5A5A;
    return w;
  endfunction

  // Bank model and scoreboard, sampled on the falling edge.
  initial begin
    fz_prev  = 1'b0;
    flt_prev = 1'b0;
    hold_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rnd_freeze && !fz_prev) begin
          check("addr_at_freeze", 32'(rnd_addr), 32'(exp_addr));
          check("freeze_in_fault", 32'(fault), 32'd0);
          mon_w  = pick_word();
          rnd_in = mon_w;
          model_word(mon_w);
          words_seen++;
        end else if (!rnd_freeze) begin
          rnd_in = 16'($urandom);
        end
        if (hold_v) begin
          check("hold_valid", 32'(byte_valid), 32'd1);
          check("hold_data", 32'(byte_data), 32'(hold_d));
        end
        if (byte_valid && byte_ready) begin
          bytes_seen++;
          last_byte = byte_data;
          if (exp_bytes.size() == 0) begin
            check("byte_extra", 32'(bytes_seen), 32'(exp_total));
          end else begin
            exp_b = exp_bytes.pop_front();
            check("byte_data", 32'(byte_data), 32'(exp_b));
          end
        end
        if (fault && !flt_prev) check("fault_rise", 32'(fault), 32'(m_fault));
        hold_v = byte_valid && !byte_ready;
        hold_d = byte_data;
      end else begin
        hold_v = 1'b0;
      end
      fz_prev  = rnd_freeze;
      flt_prev = fault;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    en    = 1'b0;
    model_clear();
    @(posedge clk); #1;
    check("rst_freeze", 32'(rnd_freeze), 32'd0);
    check("rst_addr", 32'(rnd_addr), 32'd0);
    check("rst_data", 32'(byte_data), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_words(input int target, input int bound, input string tag);
    for (int i = 0; i < bound && words_seen < target; i++) begin
      @(posedge clk); #1;
    end
    check(tag, 32'(words_seen >= target), 32'd1);
  endtask

  task automatic wait_bytes(input int target, input int bound, input bit rnd, input string tag);
    for (int i = 0; i < bound && bytes_seen < target; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        byte_ready = ($urandom_range(0, 1) == 1);
        en         = ($urandom_range(0, 15) != 0);
      end
    end
    check(tag, 32'(bytes_seen >= target), 32'd1);
  endtask

  task automatic count_freeze(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (rnd_freeze) hi++;
    end
  endtask

  initial begin
    int t0, tf, tv, w0, b0, hi;
    rst_n      = 1'b0;
    en         = 1'b0;
    rnd_in     = 16'h0000;
    byte_ready = 1'b1;
    fixed_en   = 1'b0;
    fixed_word = 16'h0000;
    model_clear();

    // 0x5555: all ones, first-byte latency and freeze length
    do_reset();
    fixed_en = 1'b1; fixed_word = 16'h5555; byte_ready = 1'b1; en = 1'b1;
    t0 = -1; tf = -1; tv = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (t0 < 0 && rnd_freeze) t0 = cyc;
      if (t0 >= 0 && tf < 0 && !rnd_freeze) tf = cyc;
      if (t0 >= 0 && tv < 0 && byte_valid) tv = cyc;
    end
    check("freeze_len", 32'(tf - t0), 32'd7);
    check("first_valid", 32'(tv - t0), 32'd16);
    wait_bytes(bytes_seen + 3, 200, 1'b0, "bytes_5555");
    check("data_5555", 32'(last_byte), 32'hFF);

    // 0x9999: alternating bits, LSB-first order
    fixed_word = 16'h9999;
    wait_bytes(bytes_seen + 4, 200, 1'b0, "bytes_9999");
    check("data_9999", 32'(last_byte), 32'h55);

    // 0x3333: no bits, address wraps past RND_N-1
    do_reset();
    fixed_en = 1'b1; fixed_word = 16'h3333; en = 1'b1;
    w0 = words_seen; b0 = bytes_seen;
    wait_words(w0 + 41, 900, "words_3333");
    check("wrap_addr", 32'(rnd_addr), 32'd4);
    check("no_fault_3333", 32'(fault), 32'd0);
    check("no_bytes_3333", 32'(bytes_seen), 32'(b0));

    // backpressure: one byte held, one accumulated, FSM idles
    do_reset();
    fixed_en = 1'b1; fixed_word = 16'h5555; byte_ready = 1'b0; en = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    count_freeze(20, hi);
    check("bp_idle_freeze", 32'(hi), 32'd0);
    check("bp_addr", 32'(rnd_addr), 32'd2);
    check("bp_valid", 32'(byte_valid), 32'd1);
    check("bp_data", 32'(byte_data), 32'hFF);
    byte_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second_valid", 32'(byte_valid), 32'd1);
    check("bp_second_data", 32'(byte_data), 32'hFF);
    wait_words(words_seen + 1, 60, "bp_resume");

    // health test: 0x1234 breaks the run, fourth consecutive 0xFFFF trips
    do_reset();
    fixed_en = 1'b0; byte_ready = 1'b1;
    dir_q = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    en = 1'b1;
    w0 = words_seen;
    wait_words(w0 + 7, 200, "words_fault");
    check("fault_pre", 32'(fault), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("fault_set", 32'(fault), 32'd1);
    count_freeze(60, hi);
    check("fault_no_freeze", 32'(hi), 32'd0);
    check("fault_sticky", 32'(fault), 32'd1);
    do_reset();

    // reset during EXTRACT, then randomized harvest with backpressure
    fixed_en = 1'b0; en = 1'b1; byte_ready = 1'b1;
    for (int i = 0; i < 40 && !rnd_freeze; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 40 && rnd_freeze; i++) begin @(posedge clk); #1; end
    check("reached_extract", 32'(rnd_freeze), 32'd0);
    repeat (2) @(posedge clk);
    do_reset();
    en = 1'b1;
    wait_bytes(bytes_seen + 25, 8000, 1'b1, "bytes_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
